// File: rtl/data_path_pkg.sv
// -----------------------------------------------------------------------------
// cpuConfig: shared types and constants for the picoMIPS execution stage.
//   A_SIZE      - ALU function select width
//   aluFunc_t   - ALU operation encodings
//   io_reg_idx  - index of the memory-mapped I/O register for a given GPR
//                 address width (always the top register)
//   IO_REG      - I/O register index for the default 3-bit register address
//   mul_state_t - sequential multiplier states
// -----------------------------------------------------------------------------
package cpuConfig;

    localparam int A_SIZE     = 3;
    localparam int R_SIZE_DEF = 3;

    typedef enum logic [A_SIZE-1:0] {
        ADD  = 3'd0,
        SUB  = 3'd1,
        AND  = 3'd2,
        OR   = 3'd3,
        XOR  = 3'd4,
        MOVE = 3'd5,
        MULL = 3'd6,
        MULH = 3'd7
    } aluFunc_t;

    function automatic int io_reg_idx(input int r_size);
        return (1 << r_size) - 1;
    endfunction

    localparam int IO_REG = io_reg_idx(R_SIZE_DEF);

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/data_path_if.sv
// -----------------------------------------------------------------------------
// data_path_if: decoded control word from the control path plus the status
// returned to it.
//   master (control path): drives writeReg, aluFunc, aluImmediate, opD, opS,
//                          opT; receives stall, zeroFlag, negFlag
//   slave  (data path)   : the mirror image
// -----------------------------------------------------------------------------
interface data_path_if #(
    parameter int N      = 8,
    parameter int R_SIZE = 3
);
    import cpuConfig::*;

    logic              writeReg;
    aluFunc_t          aluFunc;
    logic              aluImmediate;
    logic [R_SIZE-1:0] opD;
    logic [R_SIZE-1:0] opS;
    logic [N-1:0]      opT;
    logic              stall;
    logic              zeroFlag;
    logic              negFlag;

    modport master (
        output writeReg, aluFunc, aluImmediate, opD, opS, opT,
        input  stall, zeroFlag, negFlag
    );

    modport slave (
        input  writeReg, aluFunc, aluImmediate, opD, opS, opT,
        output stall, zeroFlag, negFlag
    );

endinterface

// File: rtl/data_path_mul.sv
// -----------------------------------------------------------------------------
// seq_multiplier: signed N x N shift-add multiplier, one partial product per
// cycle, working on magnitudes with a final sign fix-up.
//   clk, rst_n  - clock, async active-low reset (aborts any operation)
//   start_i     - request; accepted only in IDLE, operands latched then
//   a_i, b_i    - signed operands
//   busy_o      - iterating
//   done_o      - product_o valid this cycle (single cycle)
//   product_o   - signed 2N-bit product
//
// state | meaning
// IDLE  | waiting for start_i
// BUSY  | adding partial products for bits 0..N-2
// DONE  | bit N-1 added combinationally, signed product presented
// -----------------------------------------------------------------------------
module seq_multiplier
    import cpuConfig::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [2*N-1:0] product_o
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    mul_state_t     state_q, state_d;
    logic [N-1:0]   a_mag_q, a_mag_d;
    logic [N-1:0]   b_mag_q, b_mag_d;
    logic           sign_q, sign_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [2*N-1:0] a_ext;
    logic [2*N-1:0] partial;
    logic [2*N-1:0] mag_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MUL_IDLE;
            a_mag_q <= '0;
            b_mag_q <= '0;
            sign_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_mag_q <= a_mag_d;
            b_mag_q <= b_mag_d;
            sign_q  <= sign_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        a_ext   = {{N{1'b0}}, a_mag_q};
        partial = b_mag_q[cnt_q] ? (a_ext << cnt_q) : '0;
        mag_sum = acc_q + partial;

        state_d = state_q;
        a_mag_d = a_mag_q;
        b_mag_d = b_mag_q;
        sign_d  = sign_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;

        case (state_q)
            MUL_IDLE: begin
                if (start_i) begin
                    state_d = MUL_BUSY;
                    // -(-2^(N-1)) as an unsigned N-bit value is the correct magnitude
                    a_mag_d = a_i[N-1] ? -a_i : a_i;
                    b_mag_d = b_i[N-1] ? -b_i : b_i;
                    sign_d  = a_i[N-1] ^ b_i[N-1];
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            MUL_BUSY: begin
                acc_d = mag_sum;
                cnt_d = cnt_q + 1'b1;
                // last bit is folded in combinationally during DONE
                if (cnt_d == CNT_LAST) begin
                    state_d = MUL_DONE;
                end
            end
            MUL_DONE: begin
                state_d = MUL_IDLE;
            end
            default: begin
                state_d = MUL_IDLE;
            end
        endcase

        busy_o    = (state_q == MUL_BUSY);
        done_o    = (state_q == MUL_DONE);
        product_o = sign_q ? -mag_sum : mag_sum;
    end

endmodule

// File: rtl/data_path.sv
// -----------------------------------------------------------------------------
// data_path: picoMIPS execution stage - GPR file, ALU, status flags,
// sequential multiplier and memory-mapped switch/LED register (top GPR).
//   clk, nRst   - clock, async active-low reset
//   ctrl        - data_path_if.slave: control word in, stall/flags out
//   switchesIn  - asynchronous board switches (2-flop synchronised)
//   ledsOut     - registered LED port, loaded by writes to the I/O register
// -----------------------------------------------------------------------------
module data_path
    import cpuConfig::*;
#(
    parameter int N      = 8,
    parameter int R_SIZE = 3
) (
    input  logic         clk,
    input  logic         nRst,
    data_path_if.slave   ctrl,
    input  logic [N-1:0] switchesIn,
    output logic [N-1:0] ledsOut
);

    localparam int NREG = 1 << R_SIZE;
    localparam logic [R_SIZE-1:0] IO_IDX = R_SIZE'(io_reg_idx(R_SIZE));

    logic [N-1:0]      gpr_q [NREG];
    logic [N-1:0]      sync1_q, sync2_q;
    logic [N-1:0]      leds_q, leds_d;
    logic              zero_q, zero_d;
    logic              neg_q, neg_d;

    logic [R_SIZE-1:0] b_addr;
    logic [N-1:0]      op_a, reg_b, op_b;
    logic [N-1:0]      result;
    logic              is_mul, mul_start, mul_busy, mul_done;
    logic [2*N-1:0]    product;
    logic              stall, commit;

    seq_multiplier #(.N(N)) u_mul (
        .clk       (clk),
        .rst_n     (nRst),
        .start_i   (mul_start),
        .a_i       (op_a),
        .b_i       (op_b),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (product)
    );

    always_comb begin
        b_addr = ctrl.opT[R_SIZE-1:0];

        if (ctrl.opS == '0)          op_a = '0;
        else if (ctrl.opS == IO_IDX) op_a = sync2_q;
        else                         op_a = gpr_q[ctrl.opS];

        if (b_addr == '0)          reg_b = '0;
        else if (b_addr == IO_IDX) reg_b = sync2_q;
        else                       reg_b = gpr_q[b_addr];

        op_b = ctrl.aluImmediate ? ctrl.opT : reg_b;

        is_mul    = (ctrl.aluFunc == MULL) || (ctrl.aluFunc == MULH);
        mul_start = ctrl.writeReg && is_mul;
        // gated by nRst so a held multiply cannot re-raise stall during reset
        stall     = nRst && ((mul_start && !mul_busy && !mul_done) || mul_busy);
        commit    = ctrl.writeReg && !stall;

        case (ctrl.aluFunc)
            ADD:     result = op_a + op_b;
            SUB:     result = op_a - op_b;
            AND:     result = op_a & op_b;
            OR:      result = op_a | op_b;
            XOR:     result = op_a ^ op_b;
            MOVE:    result = op_b;
            MULL:    result = product[N-1:0];
            MULH:    result = product[2*N-1:N];
            default: result = op_b;
        endcase

        leds_d = leds_q;
        zero_d = zero_q;
        neg_d  = neg_q;
        if (commit) begin
            zero_d = (result == '0);
            neg_d  = result[N-1];
            if (ctrl.opD == IO_IDX) begin
                leds_d = result;
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            for (int i = 0; i < NREG; i++) begin
                gpr_q[i] <= '0;
            end
        end else if (commit && (ctrl.opD != '0) && (ctrl.opD != IO_IDX)) begin
            gpr_q[ctrl.opD] <= result;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            leds_q  <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            sync1_q <= switchesIn;
            sync2_q <= sync1_q;
            leds_q  <= leds_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    assign ctrl.stall    = stall;
    assign ctrl.zeroFlag = zero_q;
    assign ctrl.negFlag  = neg_q;
    assign ledsOut       = leds_q;

endmodule

// File: tb/tb_data_path.sv
// -----------------------------------------------------------------------------
// tb_data_path: self-checking bench for data_path. A reference model of the
// register file, LEDs and flags produces the expected state for each
// instruction; it is queued at issue and compared once the commit edge has
// passed. Registers are observed by copying them to the I/O register.
// -----------------------------------------------------------------------------
module tb_data_path;
    import cpuConfig::*;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic [7:0] sw = 8'h00;
    logic [7:0] leds;

    initial forever #5 clk = ~clk;

    data_path_if #(.N(N), .R_SIZE(3)) bus ();

    data_path #(.N(N), .R_SIZE(3)) dut (
        .clk        (clk),
        .nRst       (nRst),
        .ctrl       (bus),
        .switchesIn (sw),
        .ledsOut    (leds)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] m_reg [8];
    logic [7:0] m_leds;
    logic       m_z, m_ng;

    typedef struct {
        string      tag;
        logic [7:0] leds;
        logic       z;
        logic       ng;
        int         stalls;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mrd(input logic [2:0] a);
        if (a == 3'd0) return 8'h00;
        if (a == 3'd7) return sw;
        return m_reg[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
        m_leds = 8'h00;
        m_z    = 1'b0;
        m_ng   = 1'b0;
    endtask

    task automatic issue(input string tag, input aluFunc_t f, input logic [2:0] d,
                         input logic [2:0] s, input logic [7:0] t, input logic imm,
                         input logic wr, input bit scramble = 1'b0);
        logic [7:0]  a, b, res;
        logic [15:0] p;
        exp_t        e;
        int          stalls;
        int          guard;
        bit          is_mul;

        @(negedge clk);
        bus.writeReg     = wr;
        bus.aluFunc      = f;
        bus.opD          = d;
        bus.opS          = s;
        bus.opT          = t;
        bus.aluImmediate = imm;

        a = mrd(s);
        b = imm ? t : mrd(t[2:0]);
        p = {{8{a[7]}}, a} * {{8{b[7]}}, b};
        case (f)
            ADD:     res = a + b;
            SUB:     res = a - b;
            AND:     res = a & b;
            OR:      res = a | b;
            XOR:     res = a ^ b;
            MULL:    res = p[7:0];
            MULH:    res = p[15:8];
            default: res = b;
        endcase
        is_mul = (f == MULL) || (f == MULH);
        if (wr) begin
            m_z  = (res == 8'h00);
            m_ng = res[7];
            if (d == 3'd7)      m_leds = res;
            else if (d != 3'd0) m_reg[d] = res;
        end
        e.tag    = tag;
        e.leds   = m_leds;
        e.z      = m_z;
        e.ng     = m_ng;
        e.stalls = (wr && is_mul) ? N : 0;
        sb.push_back(e);

        #1;
        stalls = 0;
        guard  = 0;
        while (bus.stall && guard < 40) begin
            stalls++;
            guard++;
            @(posedge clk);
            @(negedge clk);
            if (scramble) begin
                bus.opS          = 3'($urandom);
                bus.opT          = 8'($urandom);
                bus.aluImmediate = 1'($urandom);
            end
            #1;
        end
        if (guard >= 40) check({tag, " stall timeout"}, 32'd1, 32'd0);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, " stall_cycles"}, stalls, e.stalls);
        check({e.tag, " leds"}, leds, e.leds);
        check({e.tag, " zero"}, bus.zeroFlag, e.z);
        check({e.tag, " neg"}, bus.negFlag, e.ng);
        bus.writeReg = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] r);
        issue($sformatf("read r%0d", r), MOVE, 3'd7, 3'd0, {5'b0, r}, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.writeReg     = 1'b0;
        bus.aluFunc      = ADD;
        bus.aluImmediate = 1'b0;
        bus.opD          = 3'd0;
        bus.opS          = 3'd0;
        bus.opT          = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        nRst = 1'b1;

        // preload, then reset must wipe everything
        for (int i = 1; i <= 6; i++) begin
            issue($sformatf("preload r%0d", i), MOVE, 3'(i), 3'd0, 8'(i * 17 + 3), 1'b1, 1'b1);
        end
        issue("preload leds", MOVE, 3'd7, 3'd0, 8'hA5, 1'b1, 1'b1);
        @(negedge clk);
        nRst = 1'b0;
        #1;
        check("rst stall", bus.stall, 1'b0);
        check("rst leds", leds, 8'h00);
        check("rst zero", bus.zeroFlag, 1'b0);
        check("rst neg", bus.negFlag, 1'b0);
        @(negedge clk);
        nRst = 1'b1;
        model_reset();
        for (int i = 1; i <= 6; i++) read_reg(3'(i));

        // basic arithmetic
        issue("add r1=r0+5", ADD, 3'd1, 3'd0, 8'd5, 1'b1, 1'b1);
        issue("sub r2=r1-5", SUB, 3'd2, 3'd1, 8'd5, 1'b1, 1'b1);
        issue("sub r3=r0-1", SUB, 3'd3, 3'd0, 8'd1, 1'b1, 1'b1);
        read_reg(3'd1);
        read_reg(3'd2);
        read_reg(3'd3);

        // signed multiply, operands scrambled while busy
        issue("move r1=fd", MOVE, 3'd1, 3'd0, 8'hFD, 1'b1, 1'b1);
        issue("mull r3", MULL, 3'd3, 3'd1, 8'h28, 1'b1, 1'b1, 1'b1);
        read_reg(3'd3);
        issue("mulh r4", MULH, 3'd4, 3'd1, 8'h28, 1'b1, 1'b1);
        read_reg(3'd4);

        // I/O register
        sw = 8'h5A;
        repeat (3) @(negedge clk);
        issue("move r1=r7", MOVE, 3'd1, 3'd0, 8'd7, 1'b0, 1'b1);
        read_reg(3'd1);
        issue("move r7=3c", MOVE, 3'd7, 3'd0, 8'h3C, 1'b1, 1'b1);
        issue("move r0=11", MOVE, 3'd0, 3'd0, 8'h11, 1'b1, 1'b1);
        read_reg(3'd0);

        // logic ops, register operand, same-register read/write, wrap
        issue("move r5=f0", MOVE, 3'd5, 3'd0, 8'hF0, 1'b1, 1'b1);
        issue("and r6", AND, 3'd6, 3'd5, 8'h3C, 1'b1, 1'b1);
        issue("or r6", OR, 3'd6, 3'd6, 8'd1, 1'b0, 1'b1);
        issue("xor r6", XOR, 3'd6, 3'd6, 8'hFF, 1'b1, 1'b1);
        issue("add r6 wrap", ADD, 3'd6, 3'd6, 8'hC0, 1'b1, 1'b1);
        issue("add r2=r2+1", ADD, 3'd2, 3'd2, 8'd1, 1'b1, 1'b1);
        read_reg(3'd6);
        read_reg(3'd2);

        // most-negative squared
        issue("move r2=80", MOVE, 3'd2, 3'd0, 8'h80, 1'b1, 1'b1);
        issue("mull r5=r2*r2", MULL, 3'd5, 3'd2, 8'd2, 1'b0, 1'b1);
        issue("mulh r6=r2*r2", MULH, 3'd6, 3'd2, 8'd2, 1'b0, 1'b1);
        read_reg(3'd5);
        read_reg(3'd6);

        // multiply without writeReg is a no-op
        issue("move r1=fd", MOVE, 3'd1, 3'd0, 8'hFD, 1'b1, 1'b1);
        issue("mull nowrite", MULL, 3'd3, 3'd1, 8'h05, 1'b1, 1'b0);
        read_reg(3'd3);

        // reset in the middle of a multiply
        @(negedge clk);
        bus.writeReg     = 1'b1;
        bus.aluFunc      = MULL;
        bus.opD          = 3'd4;
        bus.opS          = 3'd1;
        bus.opT          = 8'h28;
        bus.aluImmediate = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("abort busy before", bus.stall, 1'b1);
        nRst = 1'b0;
        #1;
        check("abort stall", bus.stall, 1'b0);
        check("abort leds", leds, 8'h00);
        bus.writeReg = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        model_reset();
        read_reg(3'd4);
        issue("move r1=fd", MOVE, 3'd1, 3'd0, 8'hFD, 1'b1, 1'b1);
        issue("mull after abort", MULL, 3'd4, 3'd1, 8'h28, 1'b1, 1'b1);
        read_reg(3'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_path.md
# data_path

Execution stage of the picoMIPS core, directly downstream of the control path. It consumes the decoded control word (`writeReg`, `aluFunc`, `aluImmediate`, `opD`, `opS`, `opT`) and holds the general-purpose register file and the ALU. It also contains a sequential signed shift-add multiplier that stalls the control path, and a memory-mapped switch/LED port. It returns `stall` and status flags to the control path, which uses them to freeze the PC and for conditional branches.

## Interface
- `N`, 8, data bus width
- `A_SIZE`, 3, ALU function width
- `R_SIZE`, 3, GPR address width
- `clk`  in  1  system clock, rising edge
- `nRst`  in  1  reset, asynchronous, active-low
- `writeReg`  in  1  commit ALU result to `reg[opD]`
- `aluFunc`  in  `cpuConfig::aluFunc_t`  operation select
- `aluImmediate`  in  1  operand B is `opT` (1) or `reg[opT[R_SIZE-1:0]]` (0)
- `opD`, `opS`  in  R_SIZE  destination and source register addresses
- `opT`  in  N  immediate / second register address
- `switchesIn`  in  N  asynchronous board switches
- `ledsOut`  out  N  registered LED port
- `stall`  out  1  multiplier busy; control path must hold PC and instruction
- `zeroFlag`, `negFlag`  out  1  registered status of the last committed result

## Operation
- Register file: 2^R_SIZE x N. `reg0` reads 0 and ignores writes. Address 2^R_SIZE-1 (r7) is the I/O register: reads return `switchesIn` through a 2-flop synchroniser, and writes load `ledsOut`. Registers r1..r6 are ordinary storage.
- Operands: A = `reg[opS]`; B = `aluImmediate ? opT : reg[opT[R_SIZE-1:0]]`. Reads are combinational.
- Functions (`aluFunc_t`): ADD=0, SUB=1, AND=2, OR=3, XOR=4, MOVE=5 (result = B), MULL=6, MULH=7. ADD and SUB wrap modulo 2^N, and there is no carry flag.
- MULL/MULH: signed N x N product P[2N-1:0]. MULL writes P[N-1:0]; MULH writes P[2N-1:N].
- Commit: when `writeReg`=1 and `stall`=0, the result is written to `reg[opD]` and the flags update (Z = result==0, Ng = result[N-1]). A write to r0 updates no register but does update the flags.
- A multiply starts only when `writeReg`=1. With `writeReg`=0, MULL/MULH behaves as a no-op: no stall, no flag change.
- Multiplier FSM, states IDLE, BUSY, DONE:
  - IDLE -> BUSY when a multiply is presented with `writeReg`=1. On that edge it latches |A| and |B|, sign = A[N-1]^B[N-1], and clears the accumulator and counter.
  - BUSY: one shift-add iteration per cycle. Go to DONE when the counter reaches N-1.
  - DONE: the product, negated if sign=1, is presented, committed on this edge, and the FSM returns to IDLE.
- `stall` = (state==IDLE && multiply issued with `writeReg`=1) || state==BUSY. It is deasserted in DONE, so the commit occurs on the DONE edge.

## Timing
- Reset (`nRst`=0, asynchronous): all registers, `ledsOut`, flags and synchroniser are cleared to 0. The FSM goes to IDLE and `stall`=0.
- Reset asserted mid-multiply aborts the operation immediately. No partial result is written.
- Single-cycle operations: result is visible in the register and flags one edge after issue.
- Multiply: the instruction is held for N+1 cycles. `stall` is high for cycles 0..N-1 (N cycles) and low in cycle N, and the result commits at the end of cycle N.
- Switch-to-register read latency: 2 edges of synchroniser.
- `ledsOut` changes on the edge that commits a write to r7.
- Reading and writing the same register in one cycle: the old value is read and the new value is stored.
- Upstream operand changes during BUSY are ignored, because the operands are latched.

## Structure
- `cpuConfig` package: `aluFunc_t` enum (encodings above) and the I/O register index constant.
- One sub-module, `seq_multiplier`: FSM, counter of width $clog2(N), accumulator, sign fix-up. It has `start`/`busy`/`done` handshake and a 2N-bit product.
- Register file, ALU mux, flags and I/O port live in `data_path`.

## Test plan
- Reset: preload registers, then pulse `nRst` low. Required: all reads 0, `ledsOut`=0x00, `stall`=0, Z=Ng=0.
- ADD r1=r0+5 (imm) -> r1=0x05, Z=0. Then SUB r2=r1-5 (imm) -> r2=0x00, Z=1. Then SUB r3=r0-1 -> r3=0xFF, Ng=1.
- Set r1=0xFD (-3), then MULL r3=r1*0x28 -> `stall` high exactly 8 cycles, r3=0x88 on the 9th edge, Ng=1. MULH r4=r1*0x28 -> r4=0xFF.
- I/O:
  - `switchesIn`=0x5A, wait 2 cycles, MOVE r1=r7 -> r1=0x5A.
  - MOVE r7=0x3C (imm) -> `ledsOut`=0x3C next edge.
  - MOVE r0=0x11 -> r0 reads 0, Z=0.
- Pull `nRst` low at BUSY cycle 4 of a multiply -> `stall`=0 asynchronously and the destination is unchanged. After release, a new multiply again stalls 8 cycles.
- MULL with `writeReg`=0 -> `stall` never asserts, and registers and flags are unchanged.
